// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package regfile_pkg;

  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; owns the priority pointer, grant is combinational.
module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Req,
  output logic [1:0] Gnt
);

  logic r_prio;

  always_comb begin
    Gnt = Req;
    if (Req == 2'b11) begin
      Gnt = r_prio ? 2'b10 : 2'b01;
    end
  end

  // Toggling on contention leaves the pointer on the requester that just lost.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_prio <= 1'b0;
    end else if (Req == 2'b11) begin
      r_prio <= ~r_prio;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and busy scoreboard in front of the register file.
// Optional read bypass enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_sched
  import regfile_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0_V,
  input  reg_addr_t         Req0_A,
  input  reg_data_t         Req0_D,
  output logic              Req0_Rdy,
  input  logic              Req1_V,
  input  reg_addr_t         Req1_A,
  input  reg_data_t         Req1_D,
  output logic              Req1_Rdy,
  input  logic              Rsv_V,
  input  reg_addr_t         Rsv_A,
  output reg_addr_t         Wr,
  output reg_data_t         D,
  output logic              We,
  output logic [NREG-1:0]   Busy,
  input  reg_addr_t         Ra,
  input  reg_addr_t         Rb,
  input  reg_data_t         Qa,
  input  reg_data_t         Qb,
  output reg_data_t         Fa,
  output reg_data_t         Fb
);

  logic [1:0]      w_gnt;
  logic            w_fire;
  reg_addr_t       w_wa;
  reg_data_t       w_wd;
  logic            w_wa_nz;
  logic [NREG-1:0] w_busy_nxt;

  reg_addr_t       r_wr;
  reg_data_t       r_d;
  logic            r_we;
  logic [NREG-1:0] r_busy;

  rr_arb2 u_arb (
    .Clk (Clk),
    .Rst (Rst),
    .Req ({Req1_V, Req0_V}),
    .Gnt (w_gnt)
  );

  assign Req0_Rdy = w_gnt[0];
  assign Req1_Rdy = w_gnt[1];
  assign w_fire   = |w_gnt;
  assign w_wa     = w_gnt[1] ? Req1_A : Req0_A;
  assign w_wd     = w_gnt[1] ? Req1_D : Req0_D;
  assign w_wa_nz  = (w_wa != reg_addr_t'(ZERO_REG));

  // Set is applied after clear so a fresh reservation survives its old write-back.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_fire && w_wa_nz) begin
      w_busy_nxt[w_wa] = 1'b0;
    end
    if (Rsv_V && (Rsv_A != reg_addr_t'(ZERO_REG))) begin
      w_busy_nxt[Rsv_A] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_we   <= 1'b0;
      r_wr   <= '0;
      r_d    <= '0;
      r_busy <= '0;
    end else begin
      r_we   <= w_fire && w_wa_nz;
      r_busy <= w_busy_nxt;
      if (w_fire) begin
        r_wr <= w_wa;
        r_d  <= w_wd;
      end
    end
  end

  assign We   = r_we;
  assign Wr   = r_wr;
  assign D    = r_d;
  assign Busy = r_busy;

`ifdef REGFILE_WB_BYPASS_EN
  assign Fa = (r_we && (r_wr == Ra) && (Ra != reg_addr_t'(ZERO_REG))) ? r_d : Qa;
  assign Fb = (r_we && (r_wr == Rb) && (Rb != reg_addr_t'(ZERO_REG))) ? r_d : Qb;
`else
  logic w_unused_rd_addr;
  assign w_unused_rd_addr = ^{Ra, Rb};
  assign Fa = Qa;
  assign Fb = Qb;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized bench for regfile_wb_sched against a behavioural scoreboard model.
module tb_regfile_wb_sched;
  import regfile_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0_V, Req1_V, Rsv_V;
  logic [4:0]  Req0_A, Req1_A, Rsv_A, Ra, Rb;
  logic [31:0] Req0_D, Req1_D, Qa, Qb;
  logic        Req0_Rdy, Req1_Rdy, We;
  logic [4:0]  Wr;
  logic [31:0] D, Fa, Fb, Busy;

  always #5 Clk = ~Clk;

  regfile_wb_sched dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req0_V   (Req0_V),
    .Req0_A   (Req0_A),
    .Req0_D   (Req0_D),
    .Req0_Rdy (Req0_Rdy),
    .Req1_V   (Req1_V),
    .Req1_A   (Req1_A),
    .Req1_D   (Req1_D),
    .Req1_Rdy (Req1_Rdy),
    .Rsv_V    (Rsv_V),
    .Rsv_A    (Rsv_A),
    .Wr       (Wr),
    .D        (D),
    .We       (We),
    .Busy     (Busy),
    .Ra       (Ra),
    .Rb       (Rb),
    .Qa       (Qa),
    .Qb       (Qb),
    .Fa       (Fa),
    .Fb       (Fb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: priority owner, pending-write set, last register-file write.
  int          m_prio = 0;
  bit          m_busy [32];
  logic        m_we = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_d  = '0;
  int          m_win = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] q);
`ifdef REGFILE_WB_BYPASS_EN
    if (m_we && ra != 0 && ra == m_wr) return m_d;
`endif
    return q;
  endfunction

  task automatic idle_inputs();
    Req0_V = 0; Req0_A = 0; Req0_D = 0;
    Req1_V = 0; Req1_A = 0; Req1_D = 0;
    Rsv_V  = 0; Rsv_A  = 0;
    Ra = 0; Rb = 0; Qa = 0; Qb = 0;
  endtask

  // Called just after a rising edge with inputs applied; ends just after the next edge.
  task automatic step();
    int win;
    logic [4:0]  a;
    logic [31:0] dd;
    #2;
    if (Req0_V && Req1_V) win = m_prio;
    else if (Req0_V)      win = 0;
    else if (Req1_V)      win = 1;
    else                  win = -1;
    if (!Rst) begin
      check_eq("rdy0", Req0_Rdy, win == 0);
      check_eq("rdy1", Req1_Rdy, win == 1);
    end
    check_eq("fa", Fa, fwd(Ra, Qa));
    check_eq("fb", Fb, fwd(Rb, Qb));
    @(posedge Clk);
    if (Rst) begin
      m_prio = 0; m_we = 0; m_wr = 0; m_d = 0; m_win = -1;
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      m_win = win;
      m_we  = 0;
      if (win >= 0) begin
        a  = (win == 1) ? Req1_A : Req0_A;
        dd = (win == 1) ? Req1_D : Req0_D;
        m_wr = a;
        m_d  = dd;
        m_we = (a != 0);
        if (a != 0) m_busy[a] = 0;
      end
      if (Rsv_V && Rsv_A != 0) m_busy[Rsv_A] = 1;
      if (Req0_V && Req1_V) m_prio = 1 - m_prio;
    end
    #1;
    check_eq("we", We, m_we);
    check_eq("wr", Wr, m_wr);
    check_eq("d", D, m_d);
    check_eq("busy", Busy, model_busy());
  endtask

  logic [4:0]  seq [4];
  logic [31:0] busy_snap;

  initial begin
    idle_inputs();
    Rst = 1;
    @(posedge Clk); #1;
    step();
    Rst = 0;
    step();
    check_eq("idle_busy", Busy, 32'h0);
    check_eq("idle_we", We, 1'b0);

    // Reserve r5, then write it back two cycles later.
    Rsv_V = 1; Rsv_A = 5;
    step();
    check_eq("rsv5_busy", Busy[5], 1'b1);
    idle_inputs();
    step();
    Req0_V = 1; Req0_A = 5; Req0_D = 32'h1234;
    step();
    check_eq("wb5_we", We, 1'b1);
    check_eq("wb5_wr", Wr, 5'd5);
    check_eq("wb5_d", D, 32'h1234);
    check_eq("wb5_busy", Busy[5], 1'b0);

    // Contention after reset alternates starting with requester 0.
    idle_inputs();
    Rst = 1; step(); Rst = 0;
    Req0_V = 1; Req0_A = 3; Req0_D = 32'h33;
    Req1_V = 1; Req1_A = 4; Req1_D = 32'h44;
    for (int i = 0; i < 4; i++) begin
      step();
      seq[i] = Wr;
    end
    check_eq("rr_seq0", seq[0], 5'd3);
    check_eq("rr_seq1", seq[1], 5'd4);
    check_eq("rr_seq2", seq[2], 5'd3);
    check_eq("rr_seq3", seq[3], 5'd4);

    // Write-back to r0 handshakes but never writes.
    idle_inputs();
    Rsv_V = 1; Rsv_A = 12;
    step();
    idle_inputs();
    busy_snap = Busy;
    Req1_V = 1; Req1_A = 0; Req1_D = 32'hFFFF_FFFF;
    step();
    check_eq("r0_we", We, 1'b0);
    check_eq("r0_busy", Busy, busy_snap);

    // Reservation and write-back of the same register in one cycle.
    idle_inputs();
    Req0_V = 1; Req0_A = 7; Req0_D = 32'h77;
    Rsv_V = 1; Rsv_A = 7;
    step();
    check_eq("setwins_busy7", Busy[7], 1'b1);

    // Bypass of the just-written value.
    idle_inputs();
    Req0_V = 1; Req0_A = 9; Req0_D = 32'hA5A5_A5A5;
    step();
    idle_inputs();
    Ra = 9; Qa = 0; Rb = 8; Qb = 32'h5555_0000;
    #2;
`ifdef REGFILE_WB_BYPASS_EN
    check_eq("byp_fa", Fa, 32'hA5A5_A5A5);
`else
    check_eq("byp_fa", Fa, 32'h0);
`endif
    check_eq("byp_fb", Fb, 32'h5555_0000);
    step();

    // Random traffic; losing requesters hold their request stable.
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      Rst = ($urandom_range(0, 59) == 0);
      if (!(Req0_V && m_win != 0) || Rst) begin
        Req0_V = ($urandom_range(0, 2) != 0);
        Req0_A = 5'($urandom_range(0, 31));
        Req0_D = $urandom;
      end
      if (!(Req1_V && m_win != 1) || Rst) begin
        Req1_V = ($urandom_range(0, 2) != 0);
        Req1_A = 5'($urandom_range(0, 31));
        Req1_D = $urandom;
      end
      Rsv_V = $urandom_range(0, 1);
      Rsv_A = ($urandom_range(0, 3) == 0) ? Req0_A : 5'($urandom_range(0, 31));
      Ra = ($urandom_range(0, 1) == 1) ? Wr : 5'($urandom_range(0, 31));
      Rb = ($urandom_range(0, 1) == 1) ? Wr : 5'($urandom_range(0, 31));
      Qa = $urandom;
      Qb = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
